// File: rtl/prince_host_if.sv
// Host-side sequencer for the round-based PRINCE core: accepts a request, derives
// the direction-specific key set, launches the core and returns its result.
module prince_host_if #(
    parameter logic [63:0] ALPHA          = 64'hC0AC29B7C97C50DD,
    parameter int unsigned TIMEOUT_CYCLES = 31,
    parameter int unsigned CNT_W          = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [63:0]  in_data,
    input  logic [127:0] in_key,
    output logic         core_go,
    output logic [63:0]  core_data,
    output logic [63:0]  core_k0,
    output logic [63:0]  core_k0p,
    output logic [63:0]  core_k1,
    input  logic         core_done,
    input  logic [63:0]  core_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         out_mode,
    output logic         timeout_err,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GO,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_wdog;
    logic             r_mode;
    logic             r_in_ready;
    logic             r_core_go;
    logic             r_out_valid;
    logic             r_out_mode;
    logic             r_timeout_err;
    logic             r_busy;
    logic [63:0]      r_core_data;
    logic [63:0]      r_core_k0;
    logic [63:0]      r_core_k0p;
    logic [63:0]      r_core_k1;
    logic [63:0]      r_out_data;

    logic [63:0]      w_k0;
    logic [63:0]      w_k1;
    logic [63:0]      w_k0p;
    logic [CNT_W-1:0] w_wdog_inc;
    logic             w_expire;
    logic             w_accept;

    always_comb begin
        w_k0       = in_key[127:64];
        w_k1       = in_key[63:0];
        w_k0p      = {w_k0[0], w_k0[63:1]} ^ {63'b0, w_k0[63]};
        // Expiry is judged on the post-increment count so the abort pulse lands
        // TIMEOUT_CYCLES+1 cycles after core_go.
        w_wdog_inc = r_wdog + CNT_W'(1);
        w_expire   = (w_wdog_inc == CNT_W'(TIMEOUT_CYCLES));
        w_accept   = in_valid && r_in_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_wdog        <= '0;
            r_mode        <= 1'b0;
            r_in_ready    <= 1'b0;
            r_core_go     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_mode    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
            r_core_data   <= '0;
            r_core_k0     <= '0;
            r_core_k0p    <= '0;
            r_core_k1     <= '0;
            r_out_data    <= '0;
        end else begin
            r_core_go     <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    if (w_accept) begin
                        r_core_data <= in_data;
                        r_mode      <= in_mode;
                        r_core_k0   <= in_mode ? w_k0p : w_k0;
                        r_core_k0p  <= in_mode ? w_k0 : w_k0p;
                        r_core_k1   <= in_mode ? (w_k1 ^ ALPHA) : w_k1;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_core_go   <= 1'b1;
                        r_state     <= S_GO;
                    end
                end
                S_GO: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_out_data  <= core_result;
                        r_out_mode  <= r_mode;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else if (w_expire) begin
                        r_timeout_err <= 1'b1;
                        r_in_ready    <= 1'b1;
                        r_busy        <= 1'b0;
                        r_wdog        <= '0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wdog <= w_wdog_inc;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign core_go     = r_core_go;
    assign core_data   = r_core_data;
    assign core_k0     = r_core_k0;
    assign core_k0p    = r_core_k0p;
    assign core_k1     = r_core_k1;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_mode    = r_out_mode;
    assign timeout_err = r_timeout_err;
    assign busy        = r_busy;

endmodule

// File: tb/tb_prince_host_if.sv
// Directed bench for prince_host_if: the core side is driven by hand, and expected
// values are hand-computed constants.
module tb_prince_host_if;

    localparam logic [63:0] ALPHA = 64'hC0AC29B7C97C50DD;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [63:0]  in_data;
    logic [127:0] in_key;
    logic         core_go;
    logic [63:0]  core_data;
    logic [63:0]  core_k0;
    logic [63:0]  core_k0p;
    logic [63:0]  core_k1;
    logic         core_done;
    logic [63:0]  core_result;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         out_mode;
    logic         timeout_err;
    logic         busy;

    int checks = 0;
    int errors = 0;

    prince_host_if #(
        .ALPHA(ALPHA),
        .TIMEOUT_CYCLES(31),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mode(in_mode),
        .in_data(in_data),
        .in_key(in_key),
        .core_go(core_go),
        .core_data(core_data),
        .core_k0(core_k0),
        .core_k0p(core_k0p),
        .core_k1(core_k1),
        .core_done(core_done),
        .core_result(core_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_mode(out_mode),
        .timeout_err(timeout_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until in_ready, then lets one edge accept; returns in the GO cycle.
    task automatic issue(input logic m, input logic [63:0] d, input logic [127:0] k);
        int n;
        in_mode  = m;
        in_data  = d;
        in_key   = k;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL issue_wait: in_ready=%b, expected 1 within 50 cycles", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // One-cycle core_done pulse; returns in the cycle after the pulse.
    task automatic pulse_done(input logic [63:0] r);
        core_done   = 1'b1;
        core_result = r;
        tick();
        core_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({in_ready, core_go, out_valid, timeout_err, busy, out_mode} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 000000",
                     {in_ready, core_go, out_valid, timeout_err, busy, out_mode});
        end
        checks++;
        if ({out_data, core_data, core_k0, core_k0p, core_k1} !== 320'b0) begin
            errors++;
            $display("FAIL reset_data: out_data=%h core_data=%h, expected all zero", out_data, core_data);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b busy=%b, expected 1 0", in_ready, busy);
        end
        // Reset while the core run is in flight.
        issue(1'b0, 64'h1122334455667788, 128'hFFFF0000FFFF0000_0123456789ABCDEF);
        repeat (2) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_wait_busy: got %b, expected 1", busy);
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({in_ready, core_go, out_valid, timeout_err, busy} !== 5'b0
            || {core_data, core_k0, core_k0p, core_k1} !== 256'b0) begin
            errors++;
            $display("FAIL reset_in_wait: flags=%b core_data=%h core_k1=%h, expected zeros",
                     {in_ready, core_go, out_valid, timeout_err, busy}, core_data, core_k1);
        end
        reset = 1'b1;
        pulse_done(64'hDEADBEEFDEADBEEF);
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'h0) begin
            errors++;
            $display("FAIL stale_done: out_valid=%b busy=%b in_ready=%b out_data=%h, expected 0 0 1 0",
                     out_valid, busy, in_ready, out_data);
        end
    endtask

    task automatic test_encrypt();
        out_ready = 1'b1;
        issue(1'b0, 64'h0, 128'h0);
        checks++;
        if (core_go !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL enc_go: core_go=%b in_ready=%b busy=%b, expected 1 0 1", core_go, in_ready, busy);
        end
        tick();
        checks++;
        if (core_go !== 1'b0) begin
            errors++;
            $display("FAIL enc_go_width: core_go=%b, expected 0", core_go);
        end
        repeat (12) tick();
        core_done   = 1'b1;
        core_result = 64'h818665AA0D02DFDA;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL enc_early_valid: out_valid=%b, expected 0", out_valid);
        end
        tick();
        core_done = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h818665AA0D02DFDA || out_mode !== 1'b0) begin
            errors++;
            $display("FAIL enc_result: valid=%b data=%h mode=%b, expected 1 818665aa0d02dfda 0",
                     out_valid, out_data, out_mode);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL enc_return: valid=%b in_ready=%b busy=%b, expected 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_keys();
        out_ready = 1'b1;
        issue(1'b1, 64'h0, 128'h0);
        checks++;
        if (core_k0 !== 64'h0 || core_k0p !== 64'h0 || core_k1 !== 64'hC0AC29B7C97C50DD) begin
            errors++;
            $display("FAIL dec_zero_keys: k0=%h k0p=%h k1=%h, expected 0 0 c0ac29b7c97c50dd",
                     core_k0, core_k0p, core_k1);
        end
        tick();
        pulse_done(64'h5555AAAA5555AAAA);
        checks++;
        if (out_mode !== 1'b1 || out_data !== 64'h5555AAAA5555AAAA) begin
            errors++;
            $display("FAIL dec_mode: mode=%b data=%h, expected 1 5555aaaa5555aaaa", out_mode, out_data);
        end
        tick();
        issue(1'b0, 64'h0123456789ABCDEF, 128'h8000000000000001_1111111111111111);
        checks++;
        if (core_k0 !== 64'h8000000000000001 || core_k0p !== 64'hC000000000000001
            || core_k1 !== 64'h1111111111111111 || core_data !== 64'h0123456789ABCDEF) begin
            errors++;
            $display("FAIL enc_keys: k0=%h k0p=%h k1=%h data=%h, expected 8000000000000001 c000000000000001 1111111111111111 0123456789abcdef",
                     core_k0, core_k0p, core_k1, core_data);
        end
        tick();
        pulse_done(64'h1);
        tick();
        issue(1'b1, 64'hFEDCBA9876543210, 128'h8000000000000001_1111111111111111);
        checks++;
        if (core_k0 !== 64'hC000000000000001 || core_k0p !== 64'h8000000000000001
            || core_k1 !== 64'hD1BD38A6D86D41CC || core_data !== 64'hFEDCBA9876543210) begin
            errors++;
            $display("FAIL dec_keys: k0=%h k0p=%h k1=%h data=%h, expected c000000000000001 8000000000000001 d1bd38a6d86d41cc fedcba9876543210",
                     core_k0, core_k0p, core_k1, core_data);
        end
        tick();
        pulse_done(64'h2);
        tick();
    endtask

    task automatic test_backpressure();
        logic stable_ok;
        out_ready = 1'b0;
        issue(1'b0, 64'hA5A5A5A5A5A5A5A5, 128'h0);
        tick();
        pulse_done(64'hCAFEF00DCAFEF00D);
        stable_ok = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'h0F0F0F0F0F0F0F0F;
        in_mode  = 1'b1;
        repeat (5) begin
            if (out_valid !== 1'b1 || out_data !== 64'hCAFEF00DCAFEF00D || in_ready !== 1'b0
                || core_go !== 1'b0 || out_mode !== 1'b0)
                stable_ok = 1'b0;
            tick();
        end
        checks++;
        if (stable_ok !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: valid=%b data=%h in_ready=%b, expected 1 cafef00dcafef00d 0 throughout",
                     out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || core_data !== 64'hA5A5A5A5A5A5A5A5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: valid=%b in_ready=%b core_data=%h busy=%b, expected 0 1 a5a5a5a5a5a5a5a5 0",
                     out_valid, in_ready, core_data, busy);
        end
    endtask

    task automatic test_timeout();
        logic quiet_ok;
        out_ready = 1'b1;
        issue(1'b0, 64'h3333333333333333, 128'h0);
        quiet_ok = 1'b1;
        repeat (31) begin
            tick();
            if (timeout_err !== 1'b0 || busy !== 1'b1) quiet_ok = 1'b0;
        end
        checks++;
        if (quiet_ok !== 1'b1) begin
            errors++;
            $display("FAIL to_early: timeout_err=%b busy=%b, expected 0 1 for 31 cycles", timeout_err, busy);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL to_pulse: err=%b valid=%b busy=%b in_ready=%b, expected 1 0 0 1",
                     timeout_err, out_valid, busy, in_ready);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_single: err=%b valid=%b, expected 0 0", timeout_err, out_valid);
        end
        issue(1'b1, 64'h4444444444444444, 128'h0);
        checks++;
        if (core_go !== 1'b1 || core_data !== 64'h4444444444444444) begin
            errors++;
            $display("FAIL to_recover_go: core_go=%b data=%h, expected 1 4444444444444444", core_go, core_data);
        end
        tick();
        pulse_done(64'h7777777777777777);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h7777777777777777 || out_mode !== 1'b1) begin
            errors++;
            $display("FAIL to_recover_result: valid=%b data=%h mode=%b, expected 1 7777777777777777 1",
                     out_valid, out_data, out_mode);
        end
        tick();
    endtask

    task automatic test_done_at_expiry();
        out_ready = 1'b1;
        issue(1'b0, 64'h9999999999999999, 128'h0);
        repeat (31) tick();
        pulse_done(64'hBBBBBBBBBBBBBBBB);
        checks++;
        if (out_valid !== 1'b1 || timeout_err !== 1'b0 || out_data !== 64'hBBBBBBBBBBBBBBBB) begin
            errors++;
            $display("FAIL done_at_expiry: valid=%b err=%b data=%h, expected 1 0 bbbbbbbbbbbbbbbb",
                     out_valid, timeout_err, out_data);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_at_expiry_after: err=%b in_ready=%b, expected 0 1", timeout_err, in_ready);
        end
    endtask

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_mode     = 1'b0;
        in_data     = '0;
        in_key      = '0;
        core_done   = 1'b0;
        core_result = '0;
        out_ready   = 1'b0;
        test_reset();
        test_encrypt();
        test_keys();
        test_backpressure();
        test_timeout();
        test_done_at_expiry();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/prince_host_if.md
Name: prince_host_if

Overview:
- Host-side sequencer for the round-based PRINCE core. It sits on the other end of the core controller's go/done handshake.
- Accepts encrypt/decrypt requests over a valid/ready input port and derives the key set for the requested direction: for decrypt, k0/k0' are swapped and k1 is XORed with alpha.
- Launches the core, waits for done, and returns the core result over a valid/ready output port.
- Includes a watchdog so a hung core cannot stall the host.

Parameters:
- ALPHA, 64'hC0AC29B7C97C50DD, PRINCE reflection constant XORed into k1 for decryption.
- TIMEOUT_CYCLES, 31, maximum cycles waited for core_done after go before aborting (must be >= 16).
- CNT_W, 5, width of the watchdog counter; 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_mode  input  1  0 = encrypt, 1 = decrypt.
- in_data  input  64  plaintext/ciphertext block.
- in_key  input  128  key; [127:64] = k0, [63:0] = k1.
- core_go  output  1  start pulse to the core controller.
- core_data  output  64  registered block to the core.
- core_k0  output  64  whitening key applied at input.
- core_k0p  output  64  whitening key applied at output.
- core_k1  output  64  round key.
- core_done  input  1  completion pulse from the core.
- core_result  input  64  core output, valid while core_done = 1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  64  result block.
- out_mode  output  1  mode of the returned result.
- timeout_err  output  1  one-cycle pulse when the watchdog aborts.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset = 0 at posedge):
  - State goes to IDLE; the watchdog counter clears.
  - All outputs go to 0: in_ready, core_go, out_valid, timeout_err, busy, out_mode, out_data, core_data, core_k0, core_k0p, core_k1.
  - Reset has priority in every state. An in-flight core run is abandoned and any later core_done is ignored.
- Key derivation, computed when the request is accepted:
  - k0' = {k0[0], k0[63:1]} ^ {63'b0, k0[63]}.
  - Encrypt: core_k0 = k0, core_k0p = k0', core_k1 = k1.
  - Decrypt: core_k0 = k0', core_k0p = k0, core_k1 = k1 ^ ALPHA.
- States:
  - IDLE:
    - in_ready = 1.
    - On in_valid = 1, capture in_data, the derived keys and in_mode, then go to GO. in_ready drops the following cycle.
  - GO:
    - core_go = 1 for exactly one cycle, with the captured operands stable.
    - Watchdog is cleared. Next state is WAIT.
  - WAIT:
    - Watchdog increments each cycle.
    - If core_done = 1: capture core_result into out_data and go to HOLD. core_done takes priority over a timeout in the same cycle.
    - Else, if watchdog == TIMEOUT_CYCLES: pulse timeout_err for 1 cycle and go to IDLE with out_valid = 0.
  - HOLD:
    - out_valid = 1; out_data and out_mode are held stable.
    - If out_ready = 1, go to IDLE. out_valid drops the next cycle and in_ready rises the same cycle.
- Operands:
  - core_data and the key outputs stay stable from GO until the next accepted request.
- Latency:
  - Accept edge to core_go high: 1 cycle.
  - core_done to out_valid: 1 cycle.
  - With out_ready held at 1, the block returns to IDLE 1 cycle after out_valid rises.
- Boundary conditions:
  - core_done in IDLE, GO or HOLD is ignored.
  - in_valid outside IDLE is ignored; the host must hold in_valid until in_ready.
  - A second core_done pulse in WAIT cannot occur, because the first one leaves WAIT.
  - out_ready asserted before out_valid has no effect.

Test Plan:
- Reset held low for 3 cycles, including during WAIT -> all outputs 0, state IDLE, in_ready = 1 on the first cycle after reset rises; a stale core_done is ignored.
- Encrypt (in_mode = 0, in_data = 64'h0, in_key = 128'h0), core model returns 64'h818665AA0D02DFDA after 14 cycles -> core_go pulses exactly 1 cycle, one cycle after acceptance; out_valid is high 1 cycle after core_done; out_data = 64'h818665AA0D02DFDA, out_mode = 0.
- Decrypt with k0 = 64'h0, k1 = 64'h0 -> core_k0 = 0, core_k0p = 0, core_k1 = 64'hC0AC29B7C97C50DD. With k0 = 64'h8000000000000001: encrypt gives core_k0p = 64'hC000000000000001; decrypt swaps k0/k0'.
- Backpressure: out_ready low for 5 cycles after out_valid -> out_valid and out_data stable, in_ready = 0, a new in_valid is not accepted; out_ready = 1 -> IDLE the next cycle.
- Timeout: core never asserts core_done -> timeout_err pulses once, TIMEOUT_CYCLES+1 cycles after core_go; out_valid stays 0; the next request is accepted normally.
- core_done and watchdog expiry in the same cycle -> result captured, out_valid = 1, timeout_err = 0.
